// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag positions, special-case
// encodings and format helpers, all parametrised by exponent/mantissa width.
package fp_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_QNAN,
        SP_INF,
        SP_ZERO
    } fp_special_e;

    typedef struct packed {
        fp_special_e kind;
        logic        nv;
    } fp_special_t;

    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Positive quiet NaN: all-ones exponent, only the mantissa msb set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (64'(fp_emax(exp_w)) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic man_zero);
        fp_class_e cls;
        if (exp_zero)
            cls = man_zero ? CLS_ZERO : CLS_SUB;
        else if (exp_ones)
            cls = man_zero ? CLS_INF : CLS_NAN;
        else
            cls = CLS_NORM;
        return cls;
    endfunction

    // Subnormals count as zero here, so they can also trigger INF x ZERO.
    function automatic fp_special_t fp_mul_special(input fp_class_e ca, input fp_class_e cb);
        fp_special_t sp;
        logic zero_a;
        logic zero_b;
        zero_a  = (ca == CLS_ZERO) || (ca == CLS_SUB);
        zero_b  = (cb == CLS_ZERO) || (cb == CLS_SUB);
        sp.kind = SP_NONE;
        sp.nv   = 1'b0;
        if (ca == CLS_NAN || cb == CLS_NAN) begin
            sp.kind = SP_QNAN;
        end else if ((ca == CLS_INF && zero_b) || (cb == CLS_INF && zero_a)) begin
            sp.kind = SP_QNAN;
            sp.nv   = 1'b1;
        end else if (ca == CLS_INF || cb == CLS_INF) begin
            sp.kind = SP_INF;
        end else if (zero_a || zero_b) begin
            sp.kind = SP_ZERO;
        end
        return sp;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise a double-width significand, round to nearest even, detect overflow and
// underflow (flush to zero), apply special-case overrides and pack the result.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic                      sign,
    input  logic signed [EXP_W+1:0]   exp_in,
    input  logic [2*MAN_W+1:0]        mant_in,
    input  fp_special_t               special,
    output logic [W-1:0]              result,
    output logic [3:0]                flags
);

    localparam int PW   = 2 * MAN_W + 2;
    localparam int EW   = EXP_W + 2;
    localparam logic [W-1:0]         QNAN   = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] EMAX_S = EW'(fp_emax(EXP_W));
    localparam logic signed [EW-1:0] ZERO_S = '0;

    logic [PW-2:0]          norm;
    logic [MAN_W-1:0]       kept;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [MAN_W:0]         rounded;
    logic signed [EW-1:0]   exp_norm;
    logic signed [EW-1:0]   exp_fin;

    // Drop the leading one; a product below 2.0 has it one place lower.
    assign norm     = mant_in[PW-1] ? mant_in[PW-2:0] : {mant_in[PW-3:0], 1'b0};
    assign kept     = norm[PW-2 -: MAN_W];
    assign guard    = norm[MAN_W];
    assign sticky   = |norm[MAN_W-1:0];
    assign round_up = guard & (sticky | kept[0]);
    assign rounded  = {1'b0, kept} + (MAN_W+1)'(round_up);
    assign exp_norm = exp_in + EW'(mant_in[PW-1]);
    // A carry out of rounding leaves the kept field all zero, so only e moves.
    assign exp_fin  = exp_norm + EW'(rounded[MAN_W]);

    always_comb begin
        result = '0;
        flags  = '0;
        case (special.kind)
            SP_QNAN: begin
                result         = QNAN;
                flags[FLAG_NV] = special.nv;
            end
            SP_INF:  result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SP_ZERO: result = {sign, {(W-1){1'b0}}};
            default: begin
                if (exp_fin >= EMAX_S) begin
                    result         = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags[FLAG_OF] = 1'b1;
                    flags[FLAG_NX] = 1'b1;
                end else if (exp_fin <= ZERO_S) begin
                    result         = {sign, {(W-1){1'b0}}};
                    flags[FLAG_UF] = 1'b1;
                    flags[FLAG_NX] = 1'b1;
                end else begin
                    result         = {sign, exp_fin[EXP_W-1:0], rounded[MAN_W-1:0]};
                    flags[FLAG_NX] = guard | sticky;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier (unpack / multiply / round-pack) with valid/ready
// on both sides; stalls propagate backwards through a per-stage advance chain.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] product,
    output logic [3:0]   flags
);

    localparam int STAGES = 3;
    localparam int EW     = EXP_W + 2;
    localparam int PW     = 2 * MAN_W + 2;
    localparam int BIAS   = fp_bias(EXP_W);

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MAN_W:0] ma;
        logic [MAN_W:0] mb;
        fp_special_t   special;
    } s1_t;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [PW-1:0] prod;
        fp_special_t   special;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] adv;
    fp_class_e       cls_a;
    fp_class_e       cls_b;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    logic [W-1:0]    rp_result;
    logic [3:0]      rp_flags;

    // A stage may load when it is empty or its occupant moves on this cycle.
    assign adv[3]    = !vld_pipe[3] || out_ready;
    assign adv[2]    = !vld_pipe[2] || adv[3];
    assign adv[1]    = !vld_pipe[1] || adv[2];
    assign in_ready  = adv[1];
    assign out_valid = vld_pipe[3];

    assign cls_a = fp_classify(a[W-2:MAN_W] == '0, &a[W-2:MAN_W], a[MAN_W-1:0] == '0);
    assign cls_b = fp_classify(b[W-2:MAN_W] == '0, &b[W-2:MAN_W], b[MAN_W-1:0] == '0);

    always_comb begin
        s1_d.sign    = a[W-1] ^ b[W-1];
        // Two guard bits keep the biased sum from wrapping in either direction.
        s1_d.exp     = EW'(a[W-2:MAN_W]) + EW'(b[W-2:MAN_W]) - EW'(BIAS);
        s1_d.ma      = {1'b1, a[MAN_W-1:0]};
        s1_d.mb      = {1'b1, b[MAN_W-1:0]};
        s1_d.special = fp_mul_special(cls_a, cls_b);
    end

    always_comb begin
        s2_d.sign    = s1_q.sign;
        s2_d.exp     = s1_q.exp;
        s2_d.prod    = PW'(s1_q.ma) * PW'(s1_q.mb);
        s2_d.special = s1_q.special;
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign    (s2_q.sign),
        .exp_in  ($signed(s2_q.exp)),
        .mant_in (s2_q.prod),
        .special (s2_q.special),
        .result  (rp_result),
        .flags   (rp_flags)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            product  <= '0;
            flags    <= '0;
        end else begin
            if (adv[1]) vld_pipe[1] <= in_valid;
            if (adv[2]) vld_pipe[2] <= vld_pipe[1];
            if (adv[3]) vld_pipe[3] <= vld_pipe[2];
            if (adv[1] && in_valid)    s1_q <= s1_d;
            if (adv[2] && vld_pipe[1]) s2_q <= s2_d;
            // Output registers only move on a real transfer, so they hold under stall.
            if (adv[3] && vld_pipe[2]) begin
                product <= rp_result;
                flags   <= rp_flags;
            end
        end
    end

endmodule
